alu_result_wb: RTL and testbench

Result writeback sequencer sitting directly downstream of the multicycle ALU. It captures the ALU's 32-bit `Result`, the 32-bit `ResultExtra` high word and the NZCV `ALUFlags`. It evaluates the instruction condition against the architectural flag register and updates that register. It then drives the register file's single write port, using one cycle for normal ops and two sequential cycles for long multiplies (SMULL/UMULL: low word first, then high word).

---
 rtl/alu_result_wb.sv | 121 ++++++++++++
 tb/tb_alu_result_wb.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/alu_result_wb.sv
// Result writeback sequencer: captures ALU results, evaluates the ARM condition,
// updates NZCV and drives the register-file write port (two beats for long multiplies).
module alu_result_wb (
  input  logic        clk,
  input  logic        reset,
  input  logic        Start,
  input  logic [3:0]  Cond,
  input  logic [1:0]  FlagW,
  input  logic        RegWReq,
  input  logic        Long,
  input  logic [3:0]  Rd,
  input  logic [3:0]  RdLo,
  input  logic [3:0]  RdHi,
  input  logic [3:0]  ALUFlags,
  input  logic [31:0] Result,
  input  logic [31:0] ResultExtra,
  output logic        CondEx,
  output logic [3:0]  Flags,
  output logic        WE3,
  output logic [3:0]  A3,
  output logic [31:0] WD3,
  output logic        Busy,
  output logic        Done
);

  typedef enum logic [1:0] {IDLE, WRLO, WRHI, SKIP} state_t;

  state_t      state, state_nxt;
  logic        accept;
  logic        long_q;
  logic [3:0]  rd_q, rdlo_q, rdhi_q;
  logic [31:0] result_q, extra_q;
  logic        n, z, c, v;

  assign {n, z, c, v} = Flags;
  assign accept = Start && (state == IDLE);
  assign Busy   = (state != IDLE);

  always_comb begin
    CondEx = 1'b0;
    case (Cond)
      4'b0000: CondEx = z;
      4'b0001: CondEx = !z;
      4'b0010: CondEx = c;
      4'b0011: CondEx = !c;
      4'b0100: CondEx = n;
      4'b0101: CondEx = !n;
      4'b0110: CondEx = v;
      4'b0111: CondEx = !v;
      4'b1000: CondEx = c && !z;
      4'b1001: CondEx = !c || z;
      4'b1010: CondEx = (n == v);
      4'b1011: CondEx = (n != v);
      4'b1100: CondEx = !z && (n == v);
      4'b1101: CondEx = z || (n != v);
      4'b1110: CondEx = 1'b1;
      default: CondEx = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      Flags    <= 4'b0000;
      long_q   <= 1'b0;
      rd_q     <= 4'd0;
      rdlo_q   <= 4'd0;
      rdhi_q   <= 4'd0;
      result_q <= 32'd0;
      extra_q  <= 32'd0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        long_q   <= Long;
        rd_q     <= Rd;
        rdlo_q   <= RdLo;
        rdhi_q   <= RdHi;
        result_q <= Result;
        extra_q  <= ResultExtra;
        // Flags only move when the condition passes against the pre-update flags
        if (CondEx && FlagW[1]) Flags[3:2] <= ALUFlags[3:2];
        if (CondEx && FlagW[0]) Flags[1:0] <= ALUFlags[1:0];
      end
    end
  end

  // Write port is decoded purely from state and captured operands
  always_comb begin
    state_nxt = state;
    WE3       = 1'b0;
    A3        = 4'd0;
    WD3       = 32'd0;
    Done      = 1'b0;
    case (state)
      IDLE: if (Start) state_nxt = (CondEx && RegWReq) ? WRLO : SKIP;
      WRLO: begin
        WE3 = 1'b1;
        A3  = long_q ? rdlo_q : rd_q;
        WD3 = result_q;
        if (long_q) state_nxt = WRHI;
        else begin
          state_nxt = IDLE;
          Done      = 1'b1;
        end
      end
      WRHI: begin
        WE3       = 1'b1;
        A3        = rdhi_q;
        WD3       = extra_q;
        Done      = 1'b1;
        state_nxt = IDLE;
      end
      SKIP: begin
        Done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_alu_result_wb.sv
// Bench for alu_result_wb: a cycle-list model of expected write-port activity plus
// directed vectors with hand-computed values.
module tb_alu_result_wb;

  logic        clk = 1'b0;
  logic        reset;
  logic        Start;
  logic [3:0]  Cond;
  logic [1:0]  FlagW;
  logic        RegWReq;
  logic        Long;
  logic [3:0]  Rd, RdLo, RdHi, ALUFlags;
  logic [31:0] Result, ResultExtra;
  logic        CondEx;
  logic [3:0]  Flags;
  logic        WE3;
  logic [3:0]  A3;
  logic [31:0] WD3;
  logic        Busy, Done;

  int n_chk  = 0;
  int n_pass = 0;

  alu_result_wb dut (
    .clk(clk), .reset(reset), .Start(Start), .Cond(Cond), .FlagW(FlagW),
    .RegWReq(RegWReq), .Long(Long), .Rd(Rd), .RdLo(RdLo), .RdHi(RdHi),
    .ALUFlags(ALUFlags), .Result(Result), .ResultExtra(ResultExtra),
    .CondEx(CondEx), .Flags(Flags), .WE3(WE3), .A3(A3), .WD3(WD3),
    .Busy(Busy), .Done(Done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Architectural condition table, read straight from the ISA definition
  function automatic bit cond_pass(input logic [3:0] cond, input logic [3:0] f);
    bit fn, fz, fc, fv;
    {fn, fz, fc, fv} = f;
    case (cond)
      0: return fz;          1: return !fz;
      2: return fc;          3: return !fc;
      4: return fn;          5: return !fn;
      6: return fv;          7: return !fv;
      8: return fc && !fz;   9: return !fc || fz;
      10: return fn == fv;   11: return fn != fv;
      12: return !fz && (fn == fv);
      13: return fz || (fn != fv);
      14: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // Model: each accepted op becomes a list of expected output cycles
  typedef struct packed { logic we; logic [3:0] a3; logic [31:0] wd3; logic done; } beat_t;
  beat_t      exp_q[$];
  logic [3:0] m_flags;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      exp_q.delete();
      m_flags = 4'b0000;
    end else if (exp_q.size() != 0) begin
      void'(exp_q.pop_front());
    end else if (Start) begin
      bit ce;
      ce = cond_pass(Cond, m_flags);
      if (ce && RegWReq) begin
        if (Long) begin
          exp_q.push_back('{1'b1, RdLo, Result, 1'b0});
          exp_q.push_back('{1'b1, RdHi, ResultExtra, 1'b1});
        end else exp_q.push_back('{1'b1, Rd, Result, 1'b1});
      end else exp_q.push_back('{1'b0, 4'd0, 32'd0, 1'b1});
      if (ce && FlagW[1]) m_flags[3:2] = ALUFlags[3:2];
      if (ce && FlagW[0]) m_flags[1:0] = ALUFlags[1:0];
    end
  end

  always @(negedge clk) begin
    beat_t b;
    b = (exp_q.size() != 0) ? exp_q[0] : '0;
    check("m_we3",    WE3,    b.we);
    check("m_a3",     A3,     b.a3);
    check("m_wd3",    WD3,    b.wd3);
    check("m_done",   Done,   b.done);
    check("m_busy",   Busy,   exp_q.size() != 0);
    check("m_flags",  Flags,  m_flags);
    check("m_condex", CondEx, cond_pass(Cond, m_flags));
  end

  task automatic issue(input logic [3:0] cond, input logic [1:0] fw, input logic regw,
                       input logic lng, input logic [3:0] rd, input logic [3:0] lo,
                       input logic [3:0] hi, input logic [3:0] af,
                       input logic [31:0] res, input logic [31:0] ext);
    Start = 1'b1; Cond = cond; FlagW = fw; RegWReq = regw; Long = lng;
    Rd = rd; RdLo = lo; RdHi = hi; ALUFlags = af; Result = res; ResultExtra = ext;
    @(posedge clk); #1;
    Start = 1'b0; Cond = 4'b1110; FlagW = 2'b11; ALUFlags = 4'hF;
    Result = 32'hDEAD_BEEF; ResultExtra = 32'hBAAD_F00D; Rd = 4'hE; RdLo = 4'hD; RdHi = 4'hC;
  endtask

  initial begin
    reset = 1'b1; Start = 1'b0; Cond = 4'b1110; FlagW = 2'b00; RegWReq = 1'b0;
    Long = 1'b0; Rd = 0; RdLo = 0; RdHi = 0; ALUFlags = 0; Result = 0; ResultExtra = 0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    check("rst_flags", Flags, 4'b0000);
    check("rst_we3", WE3, 1'b0);
    check("rst_busy", Busy, 1'b0);

    // Short write with AL and flag update
    issue(4'b1110, 2'b11, 1'b1, 1'b0, 4'd3, 4'd0, 4'd0, 4'b0100, 32'd5, 32'd0);
    check("short_we3", WE3, 1'b1);
    check("short_a3", A3, 4'd3);
    check("short_wd3", WD3, 32'd5);
    check("short_done", Done, 1'b1);
    check("short_flags", Flags, 4'b0100);
    @(posedge clk); #1;
    check("short_idle", WE3, 1'b0);

    // SMULL with EQ passing; Start during WRHI must be ignored
    issue(4'b0000, 2'b00, 1'b1, 1'b1, 4'd0, 4'd2, 4'd4, 4'hF, 32'hFFFF_FFFE, 32'hFFFF_FFFF);
    check("mull_lo_a3", A3, 4'd2);
    check("mull_lo_wd3", WD3, 32'hFFFF_FFFE);
    check("mull_lo_done", Done, 1'b0);
    @(posedge clk); #1;
    check("mull_hi_a3", A3, 4'd4);
    check("mull_hi_wd3", WD3, 32'hFFFF_FFFF);
    check("mull_hi_done", Done, 1'b1);
    Start = 1'b1; RegWReq = 1'b1; Long = 1'b0; ALUFlags = 4'b1111;
    @(posedge clk); #1;
    Start = 1'b0;
    check("ign_we3", WE3, 1'b0);
    check("ign_busy", Busy, 1'b0);
    check("mull_flags", Flags, 4'b0100);

    // NE fails with Z=1: no write, no flag change
    issue(4'b0001, 2'b11, 1'b1, 1'b0, 4'd5, 4'd0, 4'd0, 4'b1000, 32'h1234, 32'd0);
    check("fail_we3", WE3, 1'b0);
    check("fail_done", Done, 1'b1);
    check("fail_flags", Flags, 4'b0100);
    @(posedge clk); #1;

    // Load N=1,V=1 via a no-write op, then probe signed conditions
    issue(4'b1110, 2'b11, 1'b0, 1'b0, 4'd1, 4'd0, 4'd0, 4'b1001, 32'd9, 32'd0);
    check("skip_we3", WE3, 1'b0);
    check("skip_flags", Flags, 4'b1001);
    @(posedge clk); #1;
    Cond = 4'b1010; #1 check("ge_pass", CondEx, 1'b1);
    Cond = 4'b1011; #1 check("lt_fail", CondEx, 1'b0);
    Cond = 4'b1100; #1 check("gt_pass", CondEx, 1'b1);
    Cond = 4'b1000; #1 check("hi_fail", CondEx, 1'b0);
    Cond = 4'b1111; #1 check("nv_fail", CondEx, 1'b0);
    @(posedge clk); #1;

    // Same destination for both halves
    issue(4'b1110, 2'b00, 1'b1, 1'b1, 4'd0, 4'd7, 4'd7, 4'h0, 32'h1111, 32'h2222);
    check("same_lo_a3", A3, 4'd7);
    check("same_lo_wd3", WD3, 32'h1111);
    @(posedge clk); #1;
    check("same_hi_a3", A3, 4'd7);
    check("same_hi_wd3", WD3, 32'h2222);
    @(posedge clk); #1;

    // Reset during WRLO of a long op
    issue(4'b1110, 2'b11, 1'b1, 1'b1, 4'd0, 4'd1, 4'd2, 4'b0110, 32'hA, 32'hB);
    check("rw_we3_pre", WE3, 1'b1);
    check("rw_flags_pre", Flags, 4'b0110);
    #2 reset = 1'b1;
    #1;
    check("rw_we3_drop", WE3, 1'b0);
    check("rw_busy", Busy, 1'b0);
    check("rw_flags", Flags, 4'b0000);
    @(posedge clk); #1 reset = 1'b0;
    @(posedge clk); #1;
    check("rw_no_hi", WE3, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
